// File: rtl/vc_rr_arbiter.sv
// Round-robin scheduler that drains eight VC FIFOs into one egress FIFO.
// Each VC gets a burst of up to MAX_BURST grants, and a popped word is pushed one cycle later.
module vc_rr_arbiter #(
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [3:0]      State,
   input  logic [7:0]      empty,
   input  logic [8*DW-1:0] data_in,
   input  logic            egress_afull,
   output logic [7:0]      pop,
   output logic            push,
   output logic [DW-1:0]   data_out,
   output logic [2:0]      vc_out,
   output logic            idle_out
);

   typedef enum logic [3:0] {
      ST_RESET  = 4'b0001,
      ST_INIT   = 4'b0010,
      ST_IDLE   = 4'b0100,
      ST_ACTIVE = 4'b1000
   } ctrl_state_e;

   localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

   logic [2:0] rr_ptr_q, rr_ptr_d;
   logic [3:0] burst_cnt_q, burst_cnt_d;
   logic [2:0] last_vc_q, last_vc_d;
   logic       pend_q, pend_d;
   logic [2:0] pend_vc_q, pend_vc_d;

   logic       arb_en;
   logic       can_cont;
   logic       srch_hit;
   logic [2:0] srch_vc;
   logic       gnt_valid;
   logic [2:0] gnt_vc;

   // Find the first non-empty VC, starting at rr_ptr and wrapping modulo 8.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
      srch_hit = 1'b0;
      srch_vc  = rr_ptr_q;
      for (int k = 0; k < 8; k++) begin
         if (!srch_hit && !empty[rr_ptr_q + 3'(k)]) begin
            srch_hit = 1'b1;
            srch_vc  = rr_ptr_q + 3'(k);
         end
      end
   end

   always_comb begin
      arb_en      = (State == ST_ACTIVE) && !egress_afull && reset;
      can_cont    = (burst_cnt_q != 4'd0) && !empty[last_vc_q] && (burst_cnt_q < MAX_BURST_C);
      gnt_valid   = 1'b0;
      gnt_vc      = 3'd0;
      pop         = 8'h00;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      last_vc_d   = last_vc_q;
      pend_d      = 1'b0;
      pend_vc_d   = pend_vc_q;

      if (arb_en) begin
         if (can_cont) begin
            gnt_valid = 1'b1;
            gnt_vc    = last_vc_q;
         end else if (srch_hit) begin
            gnt_valid = 1'b1;
            gnt_vc    = srch_vc;
         end
      end

      if (gnt_valid) begin
         pop[gnt_vc] = 1'b1;
         pend_d      = 1'b1;
         pend_vc_d   = gnt_vc;
         last_vc_d   = gnt_vc;
         burst_cnt_d = can_cont ? burst_cnt_q + 4'd1 : 4'd1;
         rr_ptr_d    = can_cont ? rr_ptr_q : gnt_vc;
         if (burst_cnt_d == MAX_BURST_C) begin
            rr_ptr_d = gnt_vc + 3'd1;
         end
      end else if ((burst_cnt_q != 4'd0) && ((State != ST_ACTIVE) || !egress_afull)) begin
         // The burst is over: the VC ran dry or the controller left ACTIVE. Back-pressure alone holds the burst.
         burst_cnt_d = 4'd0;
         rr_ptr_d    = last_vc_q + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples the pre-edge values.
      if (!reset) begin
         rr_ptr_q    <= 3'd0;
         burst_cnt_q <= 4'd0;
         last_vc_q   <= 3'd0;
         pend_q      <= 1'b0;
         pend_vc_q   <= 3'd0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         last_vc_q   <= last_vc_d;
         pend_q      <= pend_d;
         pend_vc_q   <= pend_vc_d;
      end
   end

   // Reset drops a word that was popped but not yet pushed.
   assign push     = pend_q && reset;
   assign data_out = push ? data_in[pend_vc_q*DW +: DW] : '0;
   assign vc_out   = pend_vc_q;
   assign idle_out = (&empty) && !push;

endmodule

// File: tb/tb_vc_rr_arbiter.sv
// Bench for vc_rr_arbiter: behavioural VC FIFOs, a queue-based scheduling model,
// directed scenarios and a randomized run.
module tb_vc_rr_arbiter;

   localparam int DW   = 8;
   localparam int MAXB = 4;
   localparam logic [3:0] S_RESET  = 4'b0001;
   localparam logic [3:0] S_INIT   = 4'b0010;
   localparam logic [3:0] S_IDLE   = 4'b0100;
   localparam logic [3:0] S_ACTIVE = 4'b1000;

   logic            clk = 1'b0;
   logic            reset;
   logic [3:0]      State;
   logic [7:0]      empty;
   logic [8*DW-1:0] data_in;
   logic            egress_afull;
   logic [7:0]      pop;
   logic            push;
   logic [DW-1:0]   data_out;
   logic [2:0]      vc_out;
   logic            idle_out;

   vc_rr_arbiter #(.DW(DW), .MAX_BURST(MAXB)) dut (
      .clk(clk), .reset(reset), .State(State), .empty(empty), .data_in(data_in),
      .egress_afull(egress_afull), .pop(pop), .push(push), .data_out(data_out),
      .vc_out(vc_out), .idle_out(idle_out)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] fifo [8][$];
   logic [DW-1:0] dreg [8];
   int checks = 0;
   int errors = 0;

   // Model state: the VC holding the current burst, its run length, and where the next search starts.
   int m_next = 0, m_run = 0, m_last = 0, m_pend_vc = 0, m_gnt = -1;
   bit m_pend = 0, m_cont = 0;
   logic [DW-1:0] m_word = '0;
   logic [7:0]    e_pop;
   logic          e_push;
   logic [DW-1:0] e_data;
   logic [2:0]    e_vc;
   logic          e_idle;

   task automatic refresh();
      for (int i = 0; i < 8; i++) begin
         empty[i] = (fifo[i].size() == 0);
         data_in[i*DW +: DW] = dreg[i];
      end
   endtask

   task automatic model_eval();
      bit en;
      bit all_empty;
      en = reset && (State == S_ACTIVE) && !egress_afull;
      m_gnt = -1;
      m_cont = 0;
      if (en) begin
         if (m_run > 0 && m_run < MAXB && fifo[m_last].size() > 0) begin
            m_gnt = m_last;
            m_cont = 1;
         end else begin
            for (int k = 0; k < 8; k++) begin
               int v;
               v = (m_next + k) % 8;
               if (fifo[v].size() > 0) begin
                  m_gnt = v;
                  break;
               end
            end
         end
      end
      all_empty = 1;
      for (int i = 0; i < 8; i++) if (fifo[i].size() > 0) all_empty = 0;
      e_pop  = (m_gnt >= 0) ? 8'(1 << m_gnt) : 8'h00;
      e_push = m_pend && reset;
      e_data = e_push ? m_word : '0;
      e_vc   = 3'(m_pend_vc);
      e_idle = all_empty && !e_push;
   endtask

   task automatic model_update();
      if (!reset) begin
         m_next = 0; m_run = 0; m_last = 0; m_pend = 0; m_pend_vc = 0;
      end else if (m_gnt >= 0) begin
         m_word = fifo[m_gnt].pop_front();
         dreg[m_gnt] = m_word;
         m_pend = 1;
         m_pend_vc = m_gnt;
         if (m_cont) m_run = m_run + 1;
         else begin
            m_run = 1;
            m_next = m_gnt;
         end
         m_last = m_gnt;
         if (m_run == MAXB) m_next = (m_gnt + 1) % 8;
      end else begin
         m_pend = 0;
         if (m_run > 0 && (State != S_ACTIVE || !egress_afull)) begin
            m_run = 0;
            m_next = (m_last + 1) % 8;
         end
      end
   endtask

   // Called just after a negedge: settle inputs and compute the expected outputs for this cycle.
   task automatic settle();
      #1;
      model_eval();
   endtask

   // Clock edge: the FIFOs and the model react to this cycle's grant, then the bench moves on to the next negedge.
   task automatic advance();
      @(posedge clk);
      #1;
      model_update();
      refresh();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      State = S_IDLE;
      egress_afull = 1'b0;
      for (int i = 0; i < 8; i++) begin
         fifo[i].delete();
         dreg[i] = '0;
      end
      refresh();
      repeat (2) begin
         settle();
         advance();
      end
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      State = S_ACTIVE;
      egress_afull = 1'b0;
      for (int i = 0; i < 8; i++) begin
         fifo[i].push_back(8'h10 + 8'(i));
         dreg[i] = '0;
      end
      refresh();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         settle();
         checks++;
         if ({pop, push, data_out, idle_out} !== 18'h0) begin
            errors++;
            $display("FAIL reset_outputs[%0d]: got pop=%h push=%b data=%h idle=%b expected all zero", k, pop, push, data_out, idle_out);
         end
         advance();
      end
      reset = 1'b1;
      settle();
      checks++;
      if (pop !== 8'h01) begin
         errors++;
         $display("FAIL reset_first_pop: got %h expected 01", pop);
      end
      checks++;
      if ({push, vc_out} !== 4'h0) begin
         errors++;
         $display("FAIL reset_vc_out: got push=%b vc=%0d expected 0/0", push, vc_out);
      end
      advance();
   endtask

   task automatic test_burst_limit();
      int seq[8] = '{0, 0, 0, 0, 3, 3, 0, 0};
      logic [7:0] words[8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hA4, 8'hA5};
      do_reset();
      for (int i = 0; i < 6; i++) fifo[0].push_back(8'hA0 + 8'(i));
      fifo[3].push_back(8'hB0);
      fifo[3].push_back(8'hB1);
      State = S_ACTIVE;
      refresh();
      for (int k = 0; k < 10; k++) begin
         logic [7:0] xp;
         logic xpush;
         settle();
         xp = (k < 8) ? 8'(1 << seq[k]) : 8'h00;
         xpush = (k >= 1 && k <= 8);
         checks++;
         if (pop !== xp) begin
            errors++;
            $display("FAIL burst_pop[%0d]: got %h expected %h", k, pop, xp);
         end
         checks++;
         if (push !== xpush) begin
            errors++;
            $display("FAIL burst_push[%0d]: got %b expected %b", k, push, xpush);
         end
         if (xpush) begin
            checks++;
            if ({vc_out, data_out} !== {3'(seq[k-1]), words[k-1]}) begin
               errors++;
               $display("FAIL burst_word[%0d]: got vc=%0d data=%h expected vc=%0d data=%h", k, vc_out, data_out, seq[k-1], words[k-1]);
            end
         end
         if (k == 9) begin
            checks++;
            if (idle_out !== 1'b1) begin
               errors++;
               $display("FAIL burst_idle: got %b expected 1", idle_out);
            end
         end
         advance();
      end
   endtask

   task automatic test_all_vcs();
      do_reset();
      for (int i = 0; i < 8; i++) fifo[i].push_back(8'hC0 + 8'(i));
      State = S_ACTIVE;
      refresh();
      for (int k = 0; k < 10; k++) begin
         logic [7:0] xp;
         logic xpush;
         settle();
         xp = (k < 8) ? 8'(1 << k) : 8'h00;
         xpush = (k >= 1 && k <= 8);
         checks++;
         if ({pop, push} !== {xp, xpush}) begin
            errors++;
            $display("FAIL rr_pop_push[%0d]: got %h/%b expected %h/%b", k, pop, push, xp, xpush);
         end
         if (xpush) begin
            checks++;
            if ({vc_out, data_out} !== {3'(k-1), 8'hC0 + 8'(k-1)}) begin
               errors++;
               $display("FAIL rr_word[%0d]: got vc=%0d data=%h expected vc=%0d data=%h", k, vc_out, data_out, k-1, 8'hC0 + 8'(k-1));
            end
         end
         checks++;
         if (idle_out !== (k == 9)) begin
            errors++;
            $display("FAIL rr_idle[%0d]: got %b expected %b", k, idle_out, (k == 9));
         end
         advance();
      end
   endtask

   task automatic test_backpressure();
      int pv[13] = '{5, 5, -1, -1, -1, 5, 5, 6, 6, 5, 5, -1, -1};
      int nth[8] = '{default: 0};
      logic [7:0] exp_q[$];
      do_reset();
      for (int i = 0; i < 6; i++) fifo[5].push_back(8'hD0 + 8'(i));
      fifo[6].push_back(8'hE0);
      fifo[6].push_back(8'hE1);
      State = S_ACTIVE;
      for (int k = 0; k < 13; k++) begin
         logic [7:0] xp;
         logic xpush;
         egress_afull = (k >= 2 && k <= 4);
         refresh();
         settle();
         xp = (pv[k] >= 0) ? 8'(1 << pv[k]) : 8'h00;
         xpush = (k > 0) && (pv[k-1] >= 0);
         checks++;
         if ({pop, push} !== {xp, xpush}) begin
            errors++;
            $display("FAIL bp_pop_push[%0d]: got %h/%b expected %h/%b", k, pop, push, xp, xpush);
         end
         if (xpush) begin
            logic [7:0] w;
            w = exp_q.pop_front();
            checks++;
            if ({vc_out, data_out} !== {3'(pv[k-1]), w}) begin
               errors++;
               $display("FAIL bp_word[%0d]: got vc=%0d data=%h expected vc=%0d data=%h", k, vc_out, data_out, pv[k-1], w);
            end
         end
         if (pv[k] >= 0) begin
            exp_q.push_back(((pv[k] == 5) ? 8'hD0 : 8'hE0) + 8'(nth[pv[k]]));
            nth[pv[k]]++;
         end
         advance();
      end
      egress_afull = 1'b0;
   endtask

   task automatic test_state_exit();
      int pv[7] = '{2, 2, -1, -1, 4, 4, 2};
      int nth[8] = '{default: 0};
      logic [7:0] exp_q[$];
      do_reset();
      for (int i = 0; i < 6; i++) fifo[2].push_back(8'h20 + 8'(i));
      fifo[4].push_back(8'h40);
      fifo[4].push_back(8'h41);
      for (int k = 0; k < 7; k++) begin
         logic [7:0] xp;
         logic xpush;
         State = (k == 2 || k == 3) ? S_IDLE : S_ACTIVE;
         refresh();
         settle();
         xp = (pv[k] >= 0) ? 8'(1 << pv[k]) : 8'h00;
         xpush = (k > 0) && (pv[k-1] >= 0);
         checks++;
         if ({pop, push} !== {xp, xpush}) begin
            errors++;
            $display("FAIL exit_pop_push[%0d]: got %h/%b expected %h/%b", k, pop, push, xp, xpush);
         end
         if (xpush) begin
            logic [7:0] w;
            w = exp_q.pop_front();
            checks++;
            if ({vc_out, data_out} !== {3'(pv[k-1]), w}) begin
               errors++;
               $display("FAIL exit_word[%0d]: got vc=%0d data=%h expected vc=%0d data=%h", k, vc_out, data_out, pv[k-1], w);
            end
         end
         if (pv[k] >= 0) begin
            exp_q.push_back(((pv[k] == 2) ? 8'h20 : 8'h40) + 8'(nth[pv[k]]));
            nth[pv[k]]++;
         end
         advance();
      end
   endtask

   task automatic test_reset_inflight();
      do_reset();
      for (int i = 0; i < 3; i++) fifo[1].push_back(8'h50 + 8'(i));
      State = S_ACTIVE;
      refresh();
      settle();
      checks++;
      if (pop !== 8'h02) begin
         errors++;
         $display("FAIL inflight_pop: got %h expected 02", pop);
      end
      advance();
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         settle();
         checks++;
         if ({pop, push, data_out, idle_out} !== 18'h0) begin
            errors++;
            $display("FAIL inflight_reset[%0d]: got pop=%h push=%b data=%h idle=%b expected all zero", k, pop, push, data_out, idle_out);
         end
         advance();
      end
      checks++;
      if (vc_out !== 3'd0) begin
         errors++;
         $display("FAIL inflight_vc_out: got %0d expected 0", vc_out);
      end
      reset = 1'b1;
      settle();
      checks++;
      if ({pop, push} !== {8'h02, 1'b0}) begin
         errors++;
         $display("FAIL inflight_restart: got %h/%b expected 02/0", pop, push);
      end
      advance();
      settle();
      checks++;
      if ({push, vc_out, data_out} !== {1'b1, 3'd1, 8'h51}) begin
         errors++;
         $display("FAIL inflight_next_word: got push=%b vc=%0d data=%h expected 1/1/51", push, vc_out, data_out);
      end
      advance();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int v = 0; v < 8; v++) begin
            if ($urandom_range(0, 7) == 0 && fifo[v].size() < 8) fifo[v].push_back(8'($urandom));
         end
         reset = ($urandom_range(0, 99) != 0);
         case ($urandom_range(0, 11))
            0:       State = S_IDLE;
            1:       State = S_INIT;
            2:       State = S_RESET;
            default: State = S_ACTIVE;
         endcase
         egress_afull = ($urandom_range(0, 4) == 0);
         refresh();
         settle();
         checks++;
         if ({pop, push, data_out, vc_out, idle_out} !== {e_pop, e_push, e_data, e_vc, e_idle}) begin
            errors++;
            $display("FAIL random[%0d]: got pop=%h push=%b data=%h vc=%0d idle=%b expected pop=%h push=%b data=%h vc=%0d idle=%b",
                     c, pop, push, data_out, vc_out, idle_out, e_pop, e_push, e_data, e_vc, e_idle);
         end
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_burst_limit();
      test_all_vcs();
      test_backpressure();
      test_state_exit();
      test_reset_inflight();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
